// File: rtl/ravenoc_pkg.sv
// Shared AXI4 definitions for the NoC network interface: widths, burst and
// response encodings, and the packed master/slave channel bundles.
package ravenoc_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_ID_WIDTH   = 4;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_t;

  // AxSIZE encoding for a full-width beat of the given data bus width.
  function automatic logic [2:0] axi_size_for(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

  localparam logic [2:0] AXI_FULL_SIZE = axi_size_for(AXI_DATA_WIDTH);

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]     awid;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    axi_burst_t                  awburst;
    logic                        awvalid;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wlast;
    logic                        wvalid;
    logic                        bready;
    logic [AXI_ID_WIDTH-1:0]     arid;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    axi_burst_t                  arburst;
    logic                        arvalid;
    logic                        rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                        awready;
    logic                        wready;
    logic [AXI_ID_WIDTH-1:0]     bid;
    axi_resp_t                   bresp;
    logic                        bvalid;
    logic                        arready;
    logic [AXI_ID_WIDTH-1:0]     rid;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    axi_resp_t                   rresp;
    logic                        rlast;
    logic                        rvalid;
  } s_axi_miso_t;

endpackage

// File: rtl/ni_axi_master.sv
// Single-outstanding AXI4 burst master. Accepts one read or write command,
// runs the address/data/response phases, streams beats to/from the local
// side and reports completion with a one-cycle done pulse qualified by err.
//
// Handshakes: every valid/ready pair transfers on a rising clk_axi edge where
// both are high; a source keeps valid and payload stable until that edge.
// The local wr_* stream follows the same rule; rd_* has no backpressure.
module ni_axi_master
  import ravenoc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AXI_TXN_ID     = 0
) (
  input  logic                      clk_axi,
  input  logic                      arst_axi,
  output s_axi_mosi_t               axi_mosi_if,
  input  s_axi_miso_t               axi_miso_if,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]                cmd_len,
  input  logic [AXI_DATA_WIDTH-1:0] wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic [AXI_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_valid,
  output logic                      rd_last,
  output logic                      done,
  output logic                      err,
  output logic [2:0]                state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA, ST_DONE
  } state_t;

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AXI_ID_WIDTH-1:0] TXN_ID = AXI_ID_WIDTH'(AXI_TXN_ID);

  state_t                    state_q, state_n;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic [7:0]                beat_q;
  logic [TMO_W-1:0]          tmo_q;
  logic                      err_q;
  logic                      tmo_abort;

  logic cmd_fire, w_fire, r_fire, beat_fire, tmo_hit, last_beat, resp_bad;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign w_fire    = (state_q == ST_WR_DATA) && wr_valid && axi_miso_if.wready;
  assign r_fire    = (state_q == ST_RD_DATA) && axi_miso_if.rvalid;
  assign beat_fire = w_fire || r_fire;
  assign tmo_hit   = (tmo_q == TMO_LAST);
  assign last_beat = (beat_q == len_q);

  // Error sources: bad response codes, foreign IDs, and rlast disagreeing
  // with the commanded length (early or missing).
  assign resp_bad =
      ((state_q == ST_WR_RESP) && axi_miso_if.bvalid &&
       ((axi_miso_if.bresp != AXI_RESP_OKAY) || (axi_miso_if.bid != TXN_ID))) ||
      (r_fire && ((axi_miso_if.rresp != AXI_RESP_OKAY) ||
                  (axi_miso_if.rid != TXN_ID) ||
                  (axi_miso_if.rlast != last_beat)));

  assign state_dbg = state_q;

  // State register; reset forces IDLE immediately, even mid-burst.
  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) state_q <= ST_IDLE;
    else          state_q <= state_n;
  end

  // Next-state logic; a completed handshake always wins over a timeout.
  always_comb begin
    state_n   = state_q;
    tmo_abort = 1'b0;
    case (state_q)
      ST_IDLE: if (cmd_fire) state_n = cmd_write ? ST_WR_ADDR : ST_RD_ADDR;
      ST_WR_ADDR: begin
        if (axi_miso_if.awready) state_n = ST_WR_DATA;
        else if (tmo_hit)        tmo_abort = 1'b1;
      end
      ST_WR_DATA: begin
        if (w_fire && last_beat) state_n = ST_WR_RESP;
        else if (!w_fire && tmo_hit) tmo_abort = 1'b1;
      end
      ST_WR_RESP: begin
        if (axi_miso_if.bvalid) state_n = ST_DONE;
        else if (tmo_hit)       tmo_abort = 1'b1;
      end
      ST_RD_ADDR: begin
        if (axi_miso_if.arready) state_n = ST_RD_DATA;
        else if (tmo_hit)        tmo_abort = 1'b1;
      end
      ST_RD_DATA: begin
        if (r_fire && axi_miso_if.rlast) state_n = ST_DONE;
        else if (!r_fire && tmo_hit)     tmo_abort = 1'b1;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (tmo_abort) state_n = ST_DONE;
  end

  // Command latch, beat counter, timeout counter and sticky error.
  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      addr_q <= '0;
      len_q  <= '0;
      beat_q <= '0;
      tmo_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
      end
      if (state_n != state_q) beat_q <= '0;
      else if (beat_fire)     beat_q <= beat_q + 8'd1;
      if ((state_n != state_q) || beat_fire)                tmo_q <= '0;
      else if ((state_q != ST_IDLE) && (state_q != ST_DONE)) tmo_q <= tmo_q + 1'b1;
      if ((state_q == ST_DONE) || cmd_fire) err_q <= 1'b0;
      else if (tmo_abort || resp_bad)       err_q <= 1'b1;
    end
  end

  // Channel outputs decoded from the current state; payloads come straight
  // from the latched command or the local write stream.
  always_comb begin
    axi_mosi_if         = '0;
    axi_mosi_if.awid    = TXN_ID;
    axi_mosi_if.awaddr  = addr_q;
    axi_mosi_if.awlen   = len_q;
    axi_mosi_if.awsize  = AXI_FULL_SIZE;
    axi_mosi_if.awburst = AXI_BURST_INCR;
    axi_mosi_if.wdata   = wr_data;
    axi_mosi_if.wstrb   = '1;
    axi_mosi_if.arid    = TXN_ID;
    axi_mosi_if.araddr  = addr_q;
    axi_mosi_if.arlen   = len_q;
    axi_mosi_if.arsize  = AXI_FULL_SIZE;
    axi_mosi_if.arburst = AXI_BURST_INCR;
    cmd_ready = (state_q == ST_IDLE) && !arst_axi;
    wr_ready  = 1'b0;
    rd_data   = axi_miso_if.rdata;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      ST_WR_ADDR: axi_mosi_if.awvalid = 1'b1;
      ST_WR_DATA: begin
        axi_mosi_if.wvalid = wr_valid;
        axi_mosi_if.wlast  = last_beat;
        wr_ready           = axi_miso_if.wready;
      end
      ST_WR_RESP: axi_mosi_if.bready = 1'b1;
      ST_RD_ADDR: axi_mosi_if.arvalid = 1'b1;
      ST_RD_DATA: begin
        axi_mosi_if.rready = 1'b1;
        rd_valid           = axi_miso_if.rvalid;
        rd_last            = axi_miso_if.rvalid && axi_miso_if.rlast;
      end
      ST_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ni_axi_master.sv
// Bench for ni_axi_master: a behavioural AXI slave plus local-side driver,
// with expectations derived from burst length, response codes and timing.
module tb_ni_axi_master;
  import ravenoc_pkg::*;

  localparam int TMO = 16;
  localparam int TID = 5;

  logic                      clk_axi = 1'b0;
  logic                      arst_axi = 1'b1;
  s_axi_mosi_t               mosi;
  s_axi_miso_t               miso;
  logic                      cmd_valid, cmd_ready, cmd_write;
  logic [AXI_ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]                cmd_len;
  logic [AXI_DATA_WIDTH-1:0] wr_data, rd_data;
  logic                      wr_valid, wr_ready, rd_valid, rd_last, done, err;
  logic [2:0]                state_dbg;

  int total = 0;
  int bad = 0;
  logic [AXI_DATA_WIDTH-1:0] exp_q[$];

  ni_axi_master #(.TIMEOUT_CYCLES(TMO), .AXI_TXN_ID(TID)) dut (
    .clk_axi(clk_axi), .arst_axi(arst_axi),
    .axi_mosi_if(mosi), .axi_miso_if(miso),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .done(done), .err(err), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk_axi = ~clk_axi;

  task automatic clear_inputs();
    miso = '0;
    miso.bid = 4'(TID);
    miso.rid = 4'(TID);
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0;
  endtask

  // Starts and ends just after a falling edge.
  task automatic issue_cmd(input bit wr, input logic [31:0] a, input int len);
    int guard;
    guard = 0;
    #1;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk_axi); #1; guard++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL cmd_ready_idle got=%b exp=1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len[7:0];
    @(negedge clk_axi);
    cmd_valid = 1'b0;
  endtask

  task automatic post_done_check(input string name);
    #1;
    total++;
    if ({done, cmd_ready} !== 2'b01) begin
      bad++; $display("FAIL %s_after_done got done/cmd_ready=%b%b exp=01", name, done, cmd_ready);
    end
    clear_inputs();
    @(negedge clk_axi);
  endtask

  task automatic run_write(input logic [31:0] a, input int len, input int aw_wait,
                           input int wmode, input int bresp, input int abort_at);
    logic [31:0] data [256];
    logic [31:0] prev_data, exp;
    bit aw_done, pending, finished, prev_stall, exp_err;
    int beats, cyc, stall;
    aw_done = 0; pending = 0; finished = 0; prev_stall = 0;
    beats = 0; cyc = 0; stall = 0; prev_data = '0;
    exp_err = (bresp != 0);
    exp_q.delete();
    for (int i = 0; i <= len; i++) begin
      data[i] = $urandom;
      exp_q.push_back(data[i]);
    end
    issue_cmd(1'b1, a, len);
    while (!finished && cyc < 3000) begin
      if (abort_at >= 0 && aw_done && beats == abort_at) begin
        arst_axi = 1'b1;
        #1;
        total++;
        if ({mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid, mosi.rready,
             cmd_ready, wr_ready, done} !== 8'h00) begin
          bad++; $display("FAIL reset_mid_burst valids=%b exp=00000000",
            {mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid, mosi.rready,
             cmd_ready, wr_ready, done});
        end
        @(negedge clk_axi);
        arst_axi = 1'b0;
        clear_inputs();
        return;
      end
      miso.awready = (cyc >= aw_wait);
      if (aw_done && beats <= len) begin
        wr_valid = 1'b1;
        wr_data  = data[beats];
        case (wmode)
          0: miso.wready = 1'b1;
          1: miso.wready = cyc[0];
          default: miso.wready = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        endcase
      end else begin
        wr_valid = 1'b0;
        miso.wready = 1'b0;
      end
      miso.bvalid = (beats == len + 1) && ((stall >= 3) || ($urandom_range(0, 1) == 1));
      miso.bresp  = axi_resp_t'(bresp[1:0]);
      #1;
      if (pending) begin
        total++;
        if ({done, err} !== {1'b1, exp_err}) begin
          bad++; $display("FAIL wr_done got done/err=%b%b exp=1%b", done, err, exp_err);
        end
        finished = 1;
      end else begin
        total++;
        if (done !== 1'b0) begin
          bad++; $display("FAIL wr_early_done got=%b exp=0", done);
        end
        if (!aw_done) begin
          total++;
          if ({mosi.awvalid, mosi.awaddr, mosi.awlen, mosi.awsize, mosi.awburst, mosi.awid, mosi.wvalid}
              !== {1'b1, a, len[7:0], 3'd2, AXI_BURST_INCR, 4'(TID), 1'b0}) begin
            bad++; $display("FAIL aw_phase got v=%b addr=%h len=%0d size=%0d burst=%0d id=%0d exp v=1 addr=%h len=%0d size=2 burst=1 id=%0d",
              mosi.awvalid, mosi.awaddr, mosi.awlen, mosi.awsize, mosi.awburst, mosi.awid, a, len, TID);
          end
          if (miso.awready) aw_done = 1;
        end else if (beats <= len) begin
          total++;
          if ({mosi.awvalid, mosi.wvalid, wr_ready, mosi.wlast, mosi.wstrb}
              !== {1'b0, 1'b1, miso.wready, (beats == len), 4'hf}) begin
            bad++; $display("FAIL w_beat%0d got awv/wv/wr_ready/wlast/wstrb=%b%b%b%b/%h exp=01%b%b/f",
              beats, mosi.awvalid, mosi.wvalid, wr_ready, mosi.wlast, mosi.wstrb, miso.wready, (beats == len));
          end
          if (prev_stall) begin
            total++;
            if (mosi.wdata !== prev_data) begin
              bad++; $display("FAIL w_stable got=%h exp=%h", mosi.wdata, prev_data);
            end
          end
          prev_data = mosi.wdata;
          if (miso.wready) begin
            exp = exp_q.pop_front();
            total++;
            if (mosi.wdata !== exp) begin
              bad++; $display("FAIL w_data beat%0d got=%h exp=%h", beats, mosi.wdata, exp);
            end
            beats++; prev_stall = 0; stall = 0;
          end else begin
            prev_stall = 1; stall++;
          end
        end else begin
          total++;
          if ({mosi.bready, mosi.wvalid} !== 2'b10) begin
            bad++; $display("FAIL b_phase got bready/wvalid=%b%b exp=10", mosi.bready, mosi.wvalid);
          end
          if (miso.bvalid) begin pending = 1; stall = 0; end
          else stall++;
        end
      end
      @(negedge clk_axi);
      cyc++;
    end
    total++;
    if (!finished || beats != len + 1) begin
      bad++; $display("FAIL wr_complete got finished=%0d beats=%0d exp finished=1 beats=%0d", finished, beats, len + 1);
    end
    post_done_check("wr");
  endtask

  task automatic run_read(input logic [31:0] a, input int len, input int err_beat,
                          input int last_idx, input int ar_wait, input bit gaps,
                          input logic [31:0] first);
    logic [31:0] exp;
    bit ar_done, pending, finished, exp_err;
    int idx, cyc, stall;
    ar_done = 0; pending = 0; finished = 0; idx = 0; cyc = 0; stall = 0;
    exp_err = (err_beat >= 0 && err_beat <= last_idx) || (last_idx != len);
    exp_q.delete();
    issue_cmd(1'b0, a, len);
    while (!finished && cyc < 3000) begin
      miso.arready = (cyc >= ar_wait);
      miso.rvalid = 1'b0; miso.rlast = 1'b0;
      miso.rresp = AXI_RESP_OKAY; miso.rdata = $urandom;
      if (ar_done && !pending) begin
        miso.rvalid = !gaps || (stall >= 3) || ($urandom_range(0, 3) != 0);
        if (miso.rvalid) begin
          miso.rdata = (idx == 0) ? first : $urandom;
          miso.rresp = (idx == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          miso.rlast = (idx == last_idx);
          exp_q.push_back(miso.rdata);
        end
      end
      #1;
      if (pending) begin
        total++;
        if ({done, err} !== {1'b1, exp_err}) begin
          bad++; $display("FAIL rd_done got done/err=%b%b exp=1%b", done, err, exp_err);
        end
        finished = 1;
      end else begin
        total++;
        if (done !== 1'b0) begin
          bad++; $display("FAIL rd_early_done got=%b exp=0", done);
        end
        if (!ar_done) begin
          total++;
          if ({mosi.arvalid, mosi.araddr, mosi.arlen, mosi.arsize, mosi.arburst, mosi.arid, mosi.rready}
              !== {1'b1, a, len[7:0], 3'd2, AXI_BURST_INCR, 4'(TID), 1'b0}) begin
            bad++; $display("FAIL ar_phase got v=%b addr=%h len=%0d size=%0d burst=%0d id=%0d exp v=1 addr=%h len=%0d size=2 burst=1 id=%0d",
              mosi.arvalid, mosi.araddr, mosi.arlen, mosi.arsize, mosi.arburst, mosi.arid, a, len, TID);
          end
          if (miso.arready) ar_done = 1;
        end else begin
          total++;
          if ({mosi.rready, rd_valid} !== {1'b1, miso.rvalid}) begin
            bad++; $display("FAIL r_ctrl got rready/rd_valid=%b%b exp=1%b", mosi.rready, rd_valid, miso.rvalid);
          end
          if (miso.rvalid) begin
            exp = exp_q.pop_front();
            total++;
            if ({rd_data, rd_last} !== {exp, (idx == last_idx)}) begin
              bad++; $display("FAIL r_beat%0d got data=%h last=%b exp data=%h last=%b",
                idx, rd_data, rd_last, exp, (idx == last_idx));
            end
            if (idx == last_idx) pending = 1;
            idx++; stall = 0;
          end else stall++;
        end
      end
      @(negedge clk_axi);
      cyc++;
    end
    total++;
    if (!finished || idx != last_idx + 1) begin
      bad++; $display("FAIL rd_complete got finished=%0d beats=%0d exp finished=1 beats=%0d", finished, idx, last_idx + 1);
    end
    post_done_check("rd");
  endtask

  task automatic test_reset();
    clear_inputs();
    arst_axi = 1'b1;
    repeat (3) @(negedge clk_axi);
    #1;
    total++;
    if ({cmd_ready, mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid, mosi.rready,
         wr_ready, rd_valid, rd_last, done, err} !== 11'h000) begin
      bad++; $display("FAIL reset_outputs got=%b exp=00000000000",
        {cmd_ready, mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid, mosi.rready,
         wr_ready, rd_valid, rd_last, done, err});
    end
    arst_axi = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_cmd_ready got=%b exp=1", cmd_ready);
    end
    @(negedge clk_axi);
  endtask

  task automatic test_write_basic();
    run_write(32'h1000, 3, 0, 0, 0, -1);
  endtask

  task automatic test_read_single();
    run_read(32'h2000, 0, -1, 0, 0, 1'b0, 32'hDEADBEEF);
  endtask

  task automatic test_write_long();
    run_write(32'h3000, 255, 1, 1, 0, -1);
  endtask

  task automatic test_read_slverr();
    run_read(32'h4000, 3, 1, 3, 0, 1'b0, $urandom);
  endtask

  task automatic test_write_bresp_err();
    run_write(32'h4800, 2, 2, 2, 3, -1);
  endtask

  task automatic test_early_rlast();
    run_read(32'h4c00, 3, -1, 1, 1, 1'b0, $urandom);
  endtask

  task automatic test_timeout();
    int aw_cycles, guard;
    aw_cycles = 0; guard = 0;
    issue_cmd(1'b1, 32'h6000, 3);
    #1;
    while (done !== 1'b1 && guard < 100) begin
      if (mosi.awvalid === 1'b1) aw_cycles++;
      @(negedge clk_axi); #1; guard++;
    end
    total++;
    if ({done, err, mosi.awvalid} !== 3'b110 || aw_cycles != TMO) begin
      bad++; $display("FAIL timeout got done/err/awvalid=%b%b%b aw_cycles=%0d exp=110 aw_cycles=%0d",
        done, err, mosi.awvalid, aw_cycles, TMO);
    end
    @(negedge clk_axi);
    post_done_check("timeout");
  endtask

  task automatic test_reset_mid_burst();
    run_write(32'h5000, 7, 0, 0, 0, 2);
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid_idle got cmd_ready=%b exp=1", cmd_ready);
    end
    @(negedge clk_axi);
    run_write(32'h5100, 7, 0, 0, 0, -1);
  endtask

  task automatic test_random();
    int len, eb;
    for (int n = 0; n < 24; n++) begin
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        run_write($urandom, len, $urandom_range(0, 3), 2,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, -1);
      end else begin
        eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
        run_read($urandom, len, eb, len, $urandom_range(0, 3), 1'b1, $urandom);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_single();
    test_write_long();
    test_read_slverr();
    test_write_bresp_err();
    test_early_rlast();
    test_timeout();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ni_axi_master.md
NI_AXI_MASTER -- requirements
Module: ni_axi_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles waiting on any AXI response/ready before abort.
REQ-002 SHALL have parameter AXI_TXN_ID, default 0, value driven on awid/arid.
REQ-003 clk_axi  input  1  sole clock; all logic rising-edge.
REQ-004 arst_axi  input  1  reset, asynchronous, active-high.
REQ-005 axi_mosi_if  output  s_axi_mosi_t  AXI4 master-to-slave channels (AW, W, B-ready, AR, R-ready) toward NI.
REQ-006 axi_miso_if  input  s_axi_miso_t  AXI4 slave-to-master channels from NI.
REQ-007 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-008 cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr  input  AXI_ADDR_WIDTH  burst start address.
REQ-010 cmd_len  input  8  beats minus one (AXI len encoding).
REQ-011 wr_data / wr_valid / wr_ready  input / input / output  AXI_DATA_WIDTH / 1 / 1  write-beat stream.
REQ-012 rd_data / rd_valid / rd_last  output  AXI_DATA_WIDTH / 1 / 1  read-beat stream, no backpressure.
REQ-013 done / err  output  1 / 1  single-cycle completion pulse; err qualifies done (SLVERR/DECERR or timeout).

Function
REQ-014 SHALL process one command at a time; cmd_ready high only in IDLE.
REQ-015 SHALL implement states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
REQ-016 IDLE: on cmd_valid&&cmd_ready SHALL latch addr/len/write, go to WR_ADDR (write) or RD_ADDR (read).
REQ-017 WR_ADDR: awvalid=1 with latched addr, awlen=len, awsize=log2(AXI_DATA_WIDTH/8), awburst=INCR; on awready go WR_DATA.
REQ-018 WR_DATA: wr_ready = wready; wvalid = wr_valid; wdata = wr_data; wstrb all ones; wlast=1 when beat counter equals len; after last beat accepted go WR_RESP.
REQ-019 Beat counter SHALL be 8 bits, cleared on entering WR_DATA/RD_DATA, incremented per accepted beat; len=255 SHALL yield 256 beats without wrap error.
REQ-020 WR_RESP: bready=1; on bvalid capture bresp, go DONE.
REQ-021 RD_ADDR: arvalid/araddr/arlen/arsize/arburst as REQ-017; on arready go RD_DATA.
REQ-022 RD_DATA: rready=1; each rvalid beat SHALL forward rdata to rd_data with rd_valid same cycle (combinational pass, zero latency); rd_last = rlast; any non-OKAY rresp sets sticky error; on rlast go DONE.
REQ-023 Early rlast (before len beats) SHALL be accepted and flagged err=1.
REQ-024 DONE: done=1 for exactly one cycle, err = sticky error; return to IDLE next cycle; sticky error cleared.
REQ-025 AXI valids once asserted SHALL stay asserted with stable payload until ready (AXI stability rule).
REQ-026 Timeout counter SHALL reset on every state change and on every accepted beat; reaching TIMEOUT_CYCLES in any non-IDLE/non-DONE state SHALL drop all valids, set err, go DONE.
REQ-027 Command latency: awvalid/arvalid asserted the cycle after cmd handshake.

Reset
REQ-028 On arst_axi assertion SHALL go IDLE immediately, including mid-burst.
REQ-029 Reset values: all AXI valids/readies 0, cmd_ready 0 during reset then 1 in IDLE, wr_ready/rd_valid/rd_last/done/err 0, counters 0.

Structure
REQ-030 s_axi_mosi_t, s_axi_miso_t, AXI_ADDR_WIDTH, AXI_DATA_WIDTH, burst/resp encodings SHALL come from ravenoc_pkg; FSM state enum local to module.
REQ-031 Single flat module; no sub-module.

Verification
REQ-032 Write addr 0x1000, len 3, slave awready/wready always 1 -> 4 W beats, wlast on beat 4, bresp OKAY -> done=1, err=0.
REQ-033 Read addr 0x2000, len 0, rdata 0xDEADBEEF -> rd_valid one cycle with 0xDEADBEEF, rd_last=1, done next cycle, err=0.
REQ-034 Write len 255 with wready toggling every cycle -> exactly 256 beats, wlast only on 256th, payload stable while wready=0.
REQ-035 Read len 3, rresp SLVERR on beat 2 -> all 4 beats forwarded, done with err=1.
REQ-036 TIMEOUT_CYCLES=16, awready held 0 -> awvalid drops after 16 cycles, done with err=1, cmd_ready back to 1.
REQ-037 arst_axi asserted mid-write at beat 2 of 8 -> all valids 0 same cycle, IDLE after release, next command completes normally.
